// File: rtl/ifetch_buffer.sv
// ifetch_buffer: byte-serial instruction fetch buffer.
// Reads one byte per memory transaction starting at the fetch PC, assembles a
// 1/2/9/10-byte instruction (byte0 in [7:0]) and presents it with valid/ready.
// Optional feature: define FETCH_BOUNDS_CHECK_EN to stop fetching at byte
// addresses >= MEM_BYTES and report the truncated instruction with out_err.
module ifetch_buffer #(
    parameter int ADDR_W    = 64,
    parameter int MEM_BYTES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [79:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [3:0]        out_len,
    output logic              out_err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        STOP
    } state_e;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);
`else
    localparam int mem_bytes_unused = MEM_BYTES;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [3:0]        cnt_q, cnt_d;         // bytes collected so far
    logic [3:0]        len_q, len_d;         // decoded length of the instruction in flight
    logic [79:0]       slots_q, slots_d;     // bytes collected for the instruction in flight
    logic [79:0]       instr_q, instr_d;     // presented instruction
    logic [ADDR_W-1:0] opc_q, opc_d;
    logic [3:0]        olen_q, olen_d;
    logic              oerr_q, oerr_d;

    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        dec_len;
    logic              dec_err;
    logic [3:0]        cur_len;
    logic              oob;

    // Length table keyed by icode; C..F are invalid and consume one byte.
    function automatic logic [4:0] decode(input logic [3:0] icode);
        logic [4:0] r;
        case (icode)
            4'h0, 4'h1, 4'h9:        r = {1'b0, 4'd1};
            4'h2, 4'h6, 4'hA, 4'hB:  r = {1'b0, 4'd2};
            4'h7, 4'h8:              r = {1'b0, 4'd9};
            4'h3, 4'h4, 4'h5:        r = {1'b0, 4'd10};
            default:                 r = {1'b1, 4'd1};
        endcase
        return r;
    endfunction

    assign req_addr = fetch_pc_q + ADDR_W'(cnt_q);
    assign {dec_err, dec_len} = decode(mem_rdata[7:4]);
    // The length is known from the first byte onward; before that it comes from the live read data.
    assign cur_len = (cnt_q == 4'd0) ? dec_len : len_q;

`ifdef FETCH_BOUNDS_CHECK_EN
    assign oob = (req_addr >= MEM_LIMIT);
`else
    assign oob = 1'b0;
`endif

    assign out_instr = instr_q;
    assign out_pc    = opc_q;
    assign out_len   = olen_q;
    assign out_err   = oerr_q;

    // Next-state, memory request and handshake logic; pc_load overrides everything.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        slots_d    = slots_q;
        instr_d    = instr_q;
        opc_d      = opc_q;
        olen_d     = olen_q;
        oerr_d     = oerr_q;
        mem_req    = 1'b0;
        mem_addr   = '0;
        out_valid  = 1'b0;

        case (state_q)
            FETCH: begin
                mem_addr = req_addr;
                if (oob) begin
                    // Present what has been collected instead of touching memory.
                    state_d = HOLD;
                    instr_d = slots_q;
                    opc_d   = fetch_pc_q;
                    olen_d  = (cnt_q == 4'd0) ? 4'd1 : cnt_q;
                    oerr_d  = 1'b1;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        slots_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
                        cnt_d = cnt_q + 4'd1;
                        len_d = cur_len;
                        if (cnt_q + 4'd1 == cur_len) begin
                            state_d = HOLD;
                            instr_d = slots_d;
                            opc_d   = fetch_pc_q;
                            olen_d  = cur_len;
                            oerr_d  = (cnt_q == 4'd0) && dec_err;
                        end
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(olen_q);
                    cnt_d      = 4'd0;
                    len_d      = 4'd0;
                    slots_d    = '0;
                    state_d    = (oerr_q || (instr_q[7:4] == 4'h0)) ? STOP : FETCH;
                end
            end
            default: ;  // IDLE and STOP wait for a redirect
        endcase

        if (pc_load) begin
            state_d    = FETCH;
            fetch_pc_d = pc_in;
            cnt_d      = 4'd0;
            len_d      = 4'd0;
            slots_d    = '0;
            instr_d    = '0;
            opc_d      = '0;
            olen_d     = 4'd0;
            oerr_d     = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            cnt_q      <= 4'd0;
            len_q      <= 4'd0;
            slots_q    <= '0;
            instr_q    <= '0;
            opc_q      <= '0;
            olen_q     <= 4'd0;
            oerr_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            slots_q    <= slots_d;
            instr_q    <= instr_d;
            opc_q      <= opc_d;
            olen_q     <= olen_d;
            oerr_q     <= oerr_d;
        end
    end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Testbench for ifetch_buffer: directed scenarios plus a randomized phase,
// all compared against a transaction-level model of the fetch buffer.
module tb_ifetch_buffer;

    localparam int ADDR_W = 64;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam int MEMB   = 128;
    localparam bit BOUNDS = 1'b1;
`else
    localparam int MEMB   = 256;
    localparam bit BOUNDS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_in;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [79:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic [3:0]        out_len;
    logic              out_err;

    ifetch_buffer #(.ADDR_W(ADDR_W), .MEM_BYTES(MEMB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_load   (pc_load),
        .pc_in     (pc_in),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_len   (out_len),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [79:0] instr;
        logic [63:0] pc;
        logic [3:0]  len;
        logic        err;
        int          cyc;
        int          load_cyc;
    } xfer_t;

    logic [7:0]  mem [256];
    int          len_tab [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    xfer_t       xlog [$];
    logic [63:0] ack_log [$];

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          ack_pct = 100;
    bit          force_ack = 1'b0;

    // Model state: which instruction is expected and how many bytes have arrived.
    bit          m_active = 1'b0;
    bit          m_trunc = 1'b0;
    logic [63:0] m_pc = '0;
    int          m_got = 0;
    int          m_load_cyc = 0;

    int          base, abase, acks_before;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfers(input int target, input int budget);
        int n = 0;
        while (xlog.size() < target && n < budget) begin
            step();
            n++;
        end
        check("xfer_timeout", 80'(xlog.size() >= target), 80'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (out_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("valid_timeout", 80'(out_valid), 80'd1);
    endtask

    // Byte-wide memory: acks only pending requests, after a random number of wait cycles.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (force_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'hEE;
            end else if (mem_req === 1'b1 && $urandom_range(99) < ack_pct) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[7:0]];
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the expected instruction stream.
    task automatic model_cycle();
        logic [7:0]  b0;
        int          full_len, n, e_len;
        logic [63:0] cur_addr;
        logic        complete, oob, e_valid, e_req, e_err;
        logic [79:0] e_instr;
        b0       = mem[m_pc[7:0]];
        full_len = len_tab[b0[7:4]];
        cur_addr = m_pc + 64'(m_got);
        complete = m_active && !m_trunc && (m_got == full_len);
        oob      = BOUNDS && m_active && !m_trunc && !complete && (cur_addr >= 64'(MEMB));
        e_valid  = m_active && (complete || m_trunc);
        e_req    = m_active && !e_valid && !oob;
        e_instr  = '0;
        e_len    = 0;
        e_err    = 1'b0;

        check("out_valid", 80'(out_valid), 80'(e_valid));
        check("mem_req", 80'(mem_req), 80'(e_req));
        if (e_req) check("mem_addr", 80'(mem_addr), 80'(cur_addr));
        if (e_valid) begin
            n = m_trunc ? m_got : full_len;
            for (int i = 0; i < n; i++) e_instr[i*8 +: 8] = mem[8'(m_pc + 64'(i))];
            e_len = m_trunc ? ((m_got == 0) ? 1 : m_got) : full_len;
            e_err = m_trunc ? 1'b1 : (b0[7:4] >= 4'hC);
            check("out_instr", out_instr, e_instr);
            check("out_pc", 80'(out_pc), 80'(m_pc));
            check("out_len", 80'(out_len), 80'(e_len));
            check("out_err", 80'(out_err), 80'(e_err));
        end

        if (mem_req === 1'b1 && mem_ack === 1'b1) ack_log.push_back(mem_addr);
        if (e_valid && out_ready)
            xlog.push_back('{instr: e_instr, pc: m_pc, len: 4'(e_len), err: e_err,
                             cyc: cycle, load_cyc: m_load_cyc});

        if (pc_load) begin
            m_active   = 1'b1;
            m_trunc    = 1'b0;
            m_pc       = pc_in;
            m_got      = 0;
            m_load_cyc = cycle;
        end else if (e_valid && out_ready) begin
            if (e_err || e_instr[7:4] == 4'h0) m_active = 1'b0;
            m_pc    = m_pc + 64'(e_len);
            m_got   = 0;
            m_trunc = 1'b0;
        end else if (oob) begin
            m_trunc = 1'b1;
        end else if (e_req && mem_ack === 1'b1) begin
            m_got++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (rst_n !== 1'b1) begin
                m_active = 1'b0;
                m_trunc  = 1'b0;
                m_got    = 0;
                m_pc     = '0;
            end else begin
                model_cycle();
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [7:0] irm [10];
        irm = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rst_n     = 1'b0;
        pc_load   = 1'b0;
        pc_in     = '0;
        out_ready = 1'b1;
        force_ack = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // Reset held two cycles with the memory acking.
        step();
        step();
        @(negedge clk);
        check("rst_out_valid", 80'(out_valid), 80'd0);
        check("rst_mem_req", 80'(mem_req), 80'd0);
        check("rst_mem_addr", 80'(mem_addr), 80'd0);
        check("rst_out_instr", out_instr, 80'd0);
        check("rst_out_pc", 80'(out_pc), 80'd0);
        check("rst_out_len", 80'(out_len), 80'd0);
        check("rst_out_err", 80'(out_err), 80'd0);
        step();
        rst_n     = 1'b1;
        force_ack = 1'b0;
        repeat (3) step();
        check("idle_no_req", 80'(mem_req), 80'd0);

        // irmovq at 0 with zero-wait memory, followed by nop and halt.
        for (int i = 0; i < 10; i++) mem[i] = irm[i];
        mem[10] = 8'h10;
        mem[11] = 8'h00;
        base  = xlog.size();
        abase = ack_log.size();
        pc_in = '0;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        wait_xfers(base + 3, 80);
        if (xlog.size() >= base + 3) begin
            check("irm_instr", xlog[base].instr, 80'h0AF230);
            check("irm_len", 80'(xlog[base].len), 80'd10);
            check("irm_pc", 80'(xlog[base].pc), 80'd0);
            check("irm_err", 80'(xlog[base].err), 80'd0);
            check("irm_latency", 80'(xlog[base].cyc - xlog[base].load_cyc), 80'd11);
            check("irm_next_pc", 80'(xlog[base + 1].pc), 80'd10);
            check("halt_pc", 80'(xlog[base + 2].pc), 80'd11);
        end
        if (ack_log.size() >= abase + 10)
            for (int i = 0; i < 10; i++) check("irm_req_addr", 80'(ack_log[abase + i]), 80'(i));
        acks_before = ack_log.size();
        repeat (5) step();
        check("halt_stop_req", 80'(mem_req), 80'd0);
        check("halt_stop_acks", 80'(ack_log.size()), 80'(acks_before));

        // rrmovq under backpressure.
        mem[32] = 8'h20;
        mem[33] = 8'h12;
        mem[34] = 8'h00;
        base      = xlog.size();
        out_ready = 1'b0;
        pc_in     = 64'd32;
        pc_load   = 1'b1;
        step();
        pc_load = 1'b0;
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 80'(out_valid), 80'd1);
            check("bp_instr", out_instr, 80'h1220);
            check("bp_len", 80'(out_len), 80'd2);
            check("bp_pc", 80'(out_pc), 80'd32);
            check("bp_no_req", 80'(mem_req), 80'd0);
            step();
        end
        out_ready = 1'b1;
        wait_xfers(base + 2, 40);
        if (xlog.size() >= base + 2) check("bp_next_pc", 80'(xlog[base + 1].pc), 80'd34);

        // Halt, then an invalid icode, then a restart.
        mem[48] = 8'h00;
        mem[56] = 8'hF0;
        base    = xlog.size();
        pc_in   = 64'd48;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        wait_xfers(base + 1, 20);
        if (xlog.size() >= base + 1) begin
            check("halt_len", 80'(xlog[base].len), 80'd1);
            check("halt_err", 80'(xlog[base].err), 80'd0);
        end
        acks_before = ack_log.size();
        repeat (4) step();
        check("halt_acks", 80'(ack_log.size()), 80'(acks_before));
        pc_in   = 64'd56;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        wait_xfers(base + 2, 20);
        if (xlog.size() >= base + 2) begin
            check("inv_instr", xlog[base + 1].instr, 80'hF0);
            check("inv_len", 80'(xlog[base + 1].len), 80'd1);
            check("inv_err", 80'(xlog[base + 1].err), 80'd1);
        end
        repeat (4) step();
        check("inv_stop_req", 80'(mem_req), 80'd0);
        pc_in   = 64'd32;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        wait_xfers(base + 3, 40);
        if (xlog.size() >= base + 3) check("restart_pc", 80'(xlog[base + 2].pc), 80'd32);

        // Redirect during byte 3 of a jXX.
        mem[8'h50] = 8'h70;
        for (int i = 1; i < 9; i++) mem[8'h50 + i] = 8'(8'h11 * i);
        mem[8'h40] = 8'h10;
        mem[8'h41] = 8'h00;
        base    = xlog.size();
        pc_in   = 64'h50;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        step();
        step();
        check("rd_byte3_addr", 80'(mem_addr), 80'h52);
        pc_in   = 64'h40;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        check("rd_new_addr", 80'(mem_addr), 80'h40);
        wait_xfers(base + 2, 40);
        repeat (5) step();
        check("rd_xfer_count", 80'(xlog.size()), 80'(base + 2));
        if (xlog.size() >= base + 1) check("rd_first_pc", 80'(xlog[base].pc), 80'h40);

`ifdef FETCH_BOUNDS_CHECK_EN
        // irmovq straddling the end of memory.
        for (int i = 0; i < 10; i++) mem[MEMB - 6 + i] = irm[i];
        base    = xlog.size();
        abase   = ack_log.size();
        pc_in   = 64'(MEMB - 6);
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        wait_xfers(base + 1, 40);
        if (xlog.size() >= base + 1) begin
            check("bnd_len", 80'(xlog[base].len), 80'd6);
            check("bnd_err", 80'(xlog[base].err), 80'd1);
            check("bnd_instr", xlog[base].instr, 80'h0AF230);
        end
        check("bnd_acks", 80'(ack_log.size() - abase), 80'd6);
        repeat (4) step();
`endif

        // Random traffic: random memory contents, wait states, backpressure and redirects.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        base = xlog.size();
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) ack_pct = $urandom_range(100, 30);
            out_ready = ($urandom_range(3) != 0);
            pc_load   = (!m_active && $urandom_range(3) == 0) || ($urandom_range(59) == 0);
            if (pc_load)
                pc_in = ($urandom_range(7) == 0) ? (64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(7)))
                                                 : 64'($urandom_range(255));
            step();
        end
        pc_load   = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();
        check("rand_progress", 80'(xlog.size() > base + 100), 80'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
